alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execution ALU that consumes the 4-bit operation code produced by the ALU control decoder.
//  Executes add/sub/logic/move/swap/compare in one cycle; runs multiply (shift-add) and
//  divide (restoring) iteratively over WIDTH cycles. A start/busy/done handshake lets the
//  datapath controller stall on multi-cycle ops. Results and flags feed the register-file
//  write-back and the branch logic.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      request; accepted only when busy==0
//  operation  in   4      op code, sampled with start
//  a          in   WIDTH  operand A (dest/first), sampled with start
//  b          in   WIDTH  operand B (source/second), sampled with start
//  busy       out  1      multi-cycle op in progress; new starts ignored
//  done       out  1      one-cycle pulse: result/flags valid this cycle
//  result     out  WIDTH  primary result (low product, quotient)
//  result_hi  out  WIDTH  secondary result (high product, remainder, swapped A)
//  zero       out  1      result==0
//  carry      out  1      add carry-out / sub,compare borrow
//  lt         out  1      compare: a<b unsigned
//  err        out  1      divide by zero or illegal op code
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; busy, done, result, result_hi, zero, carry, lt, err = 0.
//   Any in-progress mul/div is aborted; no done is produced for it.
//  FSM states: IDLE, MUL, DIV. Start is accepted at edge E0 when state==IDLE (busy==0).
//   a, b and operation are latched at E0; later input changes do not affect the op.
//  Single-cycle ops (outputs registered at E0, done=1 the following cycle, state stays IDLE):
//   0000 nop        result=0, result_hi=0
//   0001 add        {carry,result}=a+b (mod 2^WIDTH)
//   0010 sub        result=a-b, carry=borrow (a<b)
//   0101 move       result=b
//   0110 swap       result=b, result_hi=a
//   0111 and        result=a&b;   1000 or  result=a|b
//   1001 compare    result=a-b, carry=lt=(a<b), zero=(a==b)
//   1010-1111       result=0, err=1
//   Flags not listed for an op are driven 0; zero always reflects result except compare.
//  0011 mul (unsigned): E0 -> state MUL, busy=1, counter=WIDTH. One shift-add step per edge.
//   At edge E_WIDTH: {result_hi,result}=a*b, busy=0, done=1, state IDLE. Latency WIDTH cycles.
//  0100 div (unsigned): as mul via state DIV; at E_WIDTH result=a/b, result_hi=a%b.
//   b==0: no iteration; at E0 result={WIDTH{1}}, result_hi=a, err=1, done next cycle.
//  done is high exactly one cycle per accepted start; busy and done are never both 1.
//  Outputs hold their value until the next op completes (done pulse) or reset.
//  start while busy==1 is ignored (not queued). start in the cycle done==1 is accepted
//   (back-to-back, zero bubble).
//  result/flags update only on a completion edge; they are stable while busy==1.
// TESTING
//  1 add a=16'hFFFF b=1 -> result 0, zero=1, carry=1, done 1 cycle after start.
//  2 mul a=300 b=200 -> {result_hi,result}=32'h0000_EA60; busy 16 cycles; done exactly
//    16 cycles after start; start pulses during busy ignored.
//  3 div a=1000 b=7 -> result 142, result_hi 6, err=0; div a=5 b=0 -> result 16'hFFFF,
//    result_hi 5, err=1, done after 1 cycle.
//  4 swap a=16'h1234 b=16'hABCD -> result ABCD, result_hi 1234; compare a=3 b=9 ->
//    lt=1, carry=1, zero=0; compare a=9 b=9 -> zero=1, lt=0.
//  5 assert reset at cycle 8 of a mul -> all outputs 0 immediately, no done; next add
//    after release completes normally.
//  6 back-to-back: start add in same cycle as a div's done -> both done pulses, correct
//    results; op 4'b1100 -> err=1, result 0.

Source files
------------

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
//   Execution ALU driven by the 4-bit op code from the ALU control decoder.
//   add/sub/logic/move/swap/compare finish in one cycle. Unsigned multiply
//   (shift-add) and unsigned divide (restoring) iterate for WIDTH cycles.
//   The datapath controller uses start/busy/done to stall on multi-cycle ops.
//
// Handshake: a request is taken on a rising edge where start==1 and busy==0.
//   operation, a and b are captured on that edge. done pulses high for one
//   cycle when result/result_hi/flags carry the new values. start while busy
//   is dropped (not queued). start while done==1 is accepted (no bubble).
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   start      request strobe
//   operation  op code, sampled with start
//   a, b       operands, sampled with start
//   busy       multi-cycle op in flight
//   done       one-cycle completion pulse
//   result     primary result (sum, low product, quotient, ...)
//   result_hi  secondary result (high product, remainder, swapped A)
//   zero       result == 0
//   carry      add carry-out / sub and compare borrow
//   lt         compare: a < b unsigned
//   err        divide by zero or illegal op code
//   dbg_state  current FSM state (IDLE=0, MUL=1, DIV=2)
// ---------------------------------------------------------------------------
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             lt,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_MOVE = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // opnd: multiplicand for mul, divisor for div
    logic [WIDTH-1:0] opnd_q, opnd_d;
    // acc_hi/acc_lo: partial product high/low (mul) or remainder/quotient (div)
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             lt_q, lt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    // ---------------- single-cycle result path ----------------
    logic [WIDTH:0]   sc_sum;
    logic [WIDTH-1:0] sc_diff;
    logic             sc_lt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_carry;
    logic             sc_ltf;
    logic             sc_err;
    logic             sc_multi;  // op needs the iterative datapath

    assign sc_sum  = {1'b0, a} + {1'b0, b};
    assign sc_diff = a - b;
    assign sc_lt   = (a < b);

    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ltf   = 1'b0;
        sc_err   = 1'b0;
        sc_multi = 1'b0;
        case (operation)
            OP_NOP:  ;
            OP_ADD:  begin
                sc_res   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
            end
            OP_SUB:  begin
                sc_res   = sc_diff;
                sc_carry = sc_lt;
            end
            OP_MUL:  sc_multi = 1'b1;
            OP_DIV:  begin
                if (b == '0) begin
                    // Divide by zero completes immediately with a flagged error.
                    sc_res = '1;
                    sc_hi  = a;
                    sc_err = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            OP_MOVE: sc_res = b;
            OP_SWAP: begin
                sc_res = b;
                sc_hi  = a;
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_CMP:  begin
                sc_res   = sc_diff;
                sc_carry = sc_lt;
                sc_ltf   = sc_lt;
            end
            default: sc_err = 1'b1;
        endcase
    end

    // ---------------- iterative step datapath ----------------
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift {carry, hi, lo} right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, acc_hi_q} + ({(WIDTH+1){acc_lo_q[0]}} & {1'b0, opnd_q});
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the trial subtraction only if it did not go negative.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_n = {acc_lo_q[WIDTH-2:0], div_ok};

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opnd_d      = opnd_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        lt_d        = lt_q;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (sc_multi) begin
                        cnt_d    = CW'(WIDTH);
                        acc_hi_d = '0;
                        if (operation == OP_MUL) begin
                            state_d  = S_MUL;
                            opnd_d   = a;
                            acc_lo_d = b;
                        end else begin
                            state_d  = S_DIV;
                            opnd_d   = b;
                            acc_lo_d = a;
                        end
                    end else begin
                        result_d    = sc_res;
                        result_hi_d = sc_hi;
                        zero_d      = (sc_res == '0);
                        carry_d     = sc_carry;
                        lt_d        = sc_ltf;
                        err_d       = sc_err;
                        done_d      = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d    = mul_lo_n;
                    result_hi_d = mul_hi_n;
                    zero_d      = (mul_lo_n == '0);
                    carry_d     = 1'b0;
                    lt_d        = 1'b0;
                    err_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_DIV: begin
                acc_hi_d = div_rem_n;
                acc_lo_d = div_quo_n;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d    = div_quo_n;
                    result_hi_d = div_rem_n;
                    zero_d      = (div_quo_n == '0);
                    carry_d     = 1'b0;
                    lt_d        = 1'b0;
                    err_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opnd_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            lt_q        <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opnd_q      <= opnd_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            lt_q        <= lt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign lt        = lt_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         carry;
    logic         lt;
    logic         err;
    logic [1:0]   dbg_state;

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .lt        (lt),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         l;
        logic         e;
        int           lat;  // cycles from acceptance edge to completion edge
        int           st;   // cycle value right after the acceptance edge
        int           due;  // cycle value in which done must be seen
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    exp_t zero_exp;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   m;
        longint xi;
        longint yi;
        longint p;
        xi    = longint'(x);
        yi    = longint'(y);
        m.res = '0;
        m.hi  = '0;
        m.c   = 1'b0;
        m.l   = 1'b0;
        m.e   = 1'b0;
        m.lat = 0;
        m.st  = 0;
        m.due = 0;
        case (op)
            4'd0: ;
            4'd1: begin
                p     = xi + yi;
                m.res = W'(p);
                m.c   = (p >= (longint'(1) << W));
            end
            4'd2: begin
                m.res = W'(xi - yi);
                m.c   = (xi < yi);
            end
            4'd3: begin
                p     = xi * yi;
                m.res = W'(p);
                m.hi  = W'(p >> W);
                m.lat = W;
            end
            4'd4: begin
                if (yi == 0) begin
                    m.res = W'((longint'(1) << W) - 1);
                    m.hi  = x;
                    m.e   = 1'b1;
                end else begin
                    m.res = W'(xi / yi);
                    m.hi  = W'(xi % yi);
                    m.lat = W;
                end
            end
            4'd5: m.res = y;
            4'd6: begin
                m.res = y;
                m.hi  = x;
            end
            4'd7: m.res = x & y;
            4'd8: m.res = x | y;
            4'd9: begin
                m.res = W'(xi - yi);
                m.c   = (xi < yi);
                m.l   = (xi < yi);
            end
            default: m.e = 1'b1;
        endcase
        m.z = (op == 4'd9) ? (xi == yi) : (m.res == '0);
        return m;
    endfunction

    // Per-cycle compare: done/busy timing and held output values.
    logic exp_done;
    logic exp_busy;
    always @(negedge clk) begin
        exp_done = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            last     = exp_q.pop_front();
            exp_done = 1'b1;
        end
        exp_busy = (exp_q.size() > 0) && (exp_q[0].lat > 0) &&
                   (cyc >= exp_q[0].st) && (cyc < exp_q[0].due);
        chk("done",      done,      exp_done);
        chk("busy",      busy,      exp_busy);
        chk("result",    result,    last.res);
        chk("result_hi", result_hi, last.hi);
        chk("zero",      zero,      last.z);
        chk("carry",     carry,     last.c);
        chk("lt",        lt,        last.l);
        chk("err",       err,       last.e);
    end

    // ---------------- driver tasks ----------------
    // Presents one start pulse; if now==1 it drives in the current low phase.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit now, output int c0);
        exp_t e;
        if (!now) @(negedge clk);
        #1;
        operation = op;
        a         = x;
        b         = y;
        start     = 1'b1;
        if (!busy && reset) begin
            e     = model(op, x, y);
            e.st  = cyc + 1;
            e.due = cyc + 1 + e.lat;
            exp_q.push_back(e);
        end
        c0 = cyc + 1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        operation = 4'($urandom);
    endtask

    task automatic wait_done(input int max_cyc, output int seen);
        bit got;
        got  = 1'b0;
        seen = -1;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got  = 1'b1;
                seen = cyc;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done: no done within %0d cycles", max_cyc);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    vec_t vecs[10];
    int   c0;
    int   cd;
    int   seen;

    initial begin
        vecs[0] = '{4'd2, 16'd5,     16'd9};
        vecs[1] = '{4'd7, 16'hF0F0,  16'h0FF0};
        vecs[2] = '{4'd8, 16'hF000,  16'h000F};
        vecs[3] = '{4'd5, 16'h1111,  16'h2222};
        vecs[4] = '{4'd0, 16'h5555,  16'hAAAA};
        vecs[5] = '{4'd3, 16'hFFFF,  16'hFFFF};
        vecs[6] = '{4'd4, 16'hFFFF,  16'd1};
        vecs[7] = '{4'd2, 16'd0,     16'd1};
        vecs[8] = '{4'd9, 16'd9,     16'd3};
        vecs[9] = '{4'd15, 16'd1,    16'd2};

        zero_exp = model(4'd0, '0, '0);
        zero_exp.z = 1'b0;
        last     = zero_exp;

        reset     = 1'b1;
        start     = 1'b0;
        operation = 4'd0;
        a         = '0;
        b         = '0;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_err",    err,    0);
        #1 reset = 1'b1;

        // 1: add wrap
        issue(4'd1, 16'hFFFF, 16'd1, 1'b0, c0);
        wait_done(5, seen);
        chk("add_lat",    seen - c0, 0);
        chk("add_result", result, 0);
        chk("add_zero",   zero,   1);
        chk("add_carry",  carry,  1);

        // 2: mul with ignored starts while busy
        issue(4'd3, 16'd300, 16'd200, 1'b0, c0);
        issue(4'd1, 16'd5, 16'd6, 1'b0, cd);
        issue(4'd5, 16'd7, 16'd8, 1'b0, cd);
        issue(4'd4, 16'd9, 16'd0, 1'b0, cd);
        wait_done(40, seen);
        chk("mul_lat",    seen - c0, 16);
        chk("mul_lo",     result,    16'hEA60);
        chk("mul_hi",     result_hi, 16'h0000);

        // 3: divide, divide by zero
        issue(4'd4, 16'd1000, 16'd7, 1'b0, c0);
        wait_done(40, seen);
        chk("div_q",   result,    142);
        chk("div_r",   result_hi, 6);
        chk("div_err", err,       0);
        issue(4'd4, 16'd5, 16'd0, 1'b0, c0);
        wait_done(5, seen);
        chk("div0_lat", seen - c0, 0);
        chk("div0_q",   result,    16'hFFFF);
        chk("div0_r",   result_hi, 5);
        chk("div0_err", err,       1);

        // 4: swap, compare
        issue(4'd6, 16'h1234, 16'hABCD, 1'b0, c0);
        wait_done(5, seen);
        chk("swap_lo", result,    16'hABCD);
        chk("swap_hi", result_hi, 16'h1234);
        issue(4'd9, 16'd3, 16'd9, 1'b0, c0);
        wait_done(5, seen);
        chk("cmp_lt",    lt,    1);
        chk("cmp_carry", carry, 1);
        chk("cmp_zero",  zero,  0);
        issue(4'd9, 16'd9, 16'd9, 1'b0, c0);
        wait_done(5, seen);
        chk("cmpeq_zero", zero, 1);
        chk("cmpeq_lt",   lt,   0);

        // 5: reset in the middle of a multiply
        issue(4'd3, 16'd123, 16'd45, 1'b0, c0);
        repeat (7) @(negedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        last = zero_exp;
        #1;
        chk("arst_busy",   busy,      0);
        chk("arst_done",   done,      0);
        chk("arst_result", result,    0);
        chk("arst_hi",     result_hi, 0);
        chk("arst_flags",  {zero, carry, lt, err}, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);
        issue(4'd1, 16'd100, 16'd23, 1'b0, c0);
        wait_done(5, seen);
        chk("post_rst_add", result, 123);

        // 6: back-to-back start in the done cycle, then illegal op
        issue(4'd4, 16'd50000, 16'd123, 1'b0, c0);
        wait_done(40, seen);
        chk("b2b_div_q", result,    406);
        chk("b2b_div_r", result_hi, 62);
        issue(4'd1, 16'd7, 16'd8, 1'b1, c0);
        wait_done(5, seen);
        chk("b2b_add_lat", seen - c0, 0);
        chk("b2b_add",     result,    15);
        issue(4'b1100, 16'd7, 16'd8, 1'b0, c0);
        wait_done(5, seen);
        chk("ill_err",    err,    1);
        chk("ill_result", result, 0);

        // Table and a few random requests, checked by the model only.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].x, vecs[i].y, 1'b0, c0);
            wait_done(40, seen);
        end
        for (int i = 0; i < 8; i++) begin
            issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom_range(0, 40)), 1'b0, c0);
            wait_done(40, seen);
        end

        repeat (20) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
